// File: rtl/psum_mc_router_if.sv
// rtl/psum_mc_router_if.sv - psum handshake bundle between bus controller, upstream PE, router and PE
//
// Signals:
//   bus_data_in/valid/ready          psum from the global psum bus
//   last_pe_data_in/valid/ready      psum from the upstream PE chain
//   pe_psum_in/pe_psum_in_en/pe_psum_rdy  FIFO head towards the PE accumulator
// Modports:
//   slave  - router side
//   master - environment side (bus controller, upstream PE, PE)

interface psum_mc_router_if #(
    parameter int DATA_WIDTH = 16
);
    logic        [DATA_WIDTH-1:0] bus_data_in;
    logic                         bus_data_valid;
    logic                         bus_data_ready;
    logic        [DATA_WIDTH-1:0] last_pe_data_in;
    logic                         last_pe_data_valid;
    logic                         last_pe_data_ready;
    logic signed [DATA_WIDTH-1:0] pe_psum_in;
    logic                         pe_psum_in_en;
    logic                         pe_psum_rdy;

    modport slave (
        input  bus_data_in, bus_data_valid,
        input  last_pe_data_in, last_pe_data_valid,
        input  pe_psum_rdy,
        output bus_data_ready, last_pe_data_ready,
        output pe_psum_in, pe_psum_in_en
    );

    modport master (
        output bus_data_in, bus_data_valid,
        output last_pe_data_in, last_pe_data_valid,
        output pe_psum_rdy,
        input  bus_data_ready, last_pe_data_ready,
        input  pe_psum_in, pe_psum_in_en
    );
endinterface

// File: rtl/psum_mc_router.sv
// rtl/psum_mc_router.sv - buffered psum input router for one PE (bus or upstream chain into a FIFO)
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   config_state, ce  configuration phase / write enable; a write latches dest_id and flushes
//   source_id         ID currently broadcast on the psum bus
//   dest_id           configured ID {match_id, chain_sel}
//   pe_mac_finish     PE MAC finished
//   pe_ready          request to the bus controller (match && finish && !full)
//   fifo_level        FIFO occupancy
//   drop_cnt          saturating count of cycles a selected source was stalled by a full FIFO
//   bus               psum_mc_router_if.slave handshake bundle
// Options:
//   PSUM_MC_ROUTER_DROP_CNT_EN  builds the stall counter; otherwise drop_cnt is tied to 0

module psum_mc_router #(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          config_state,
    input  logic                          ce,
    input  logic [ID_WIDTH-1:0]           source_id,
    input  logic [ID_WIDTH-1:0]           dest_id,
    input  logic                          pe_mac_finish,
    output logic                          pe_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_WIDTH-1:0]          drop_cnt,
    psum_mc_router_if.slave               bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic        [ID_WIDTH-1:0]   stored_id;
    logic signed [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic        [PTR_W-1:0]      wr_ptr;
    logic        [PTR_W-1:0]      rd_ptr;
    logic        [LVL_W-1:0]      level;

    logic                  match;
    logic                  chain;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  cfg_wr;
    logic [DATA_WIDTH-1:0] push_data;

    assign cfg_wr = config_state && ce;
    assign match  = ({1'b0, stored_id[ID_WIDTH-1:1]} == source_id);
    assign chain  = stored_id[0];
    assign full   = (level == LVL_W'(FIFO_DEPTH));
    assign empty  = (level == '0);

    // Readiness depends only on registered level, never on pe_psum_rdy, so a
    // pop in a full cycle frees a slot only from the following cycle.
    assign bus.last_pe_data_ready = !config_state && chain && !full;
    assign bus.bus_data_ready     = !config_state && !chain && match && !full;

    assign push = chain ? (bus.last_pe_data_valid && bus.last_pe_data_ready)
                        : (bus.bus_data_valid && bus.bus_data_ready);
    assign push_data = chain ? bus.last_pe_data_in : bus.bus_data_in;
    assign pop  = !empty && bus.pe_psum_rdy;

    assign pe_ready          = match && pe_mac_finish && !full;
    assign fifo_level        = level;
    assign bus.pe_psum_in_en = !empty;
    assign bus.pe_psum_in    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stored_id <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
        end else if (cfg_wr) begin
            // A config write discards whatever is still queued.
            stored_id <= dest_id;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: empty entries are never presented.
    always_ff @(posedge clk) begin
        if (push && !cfg_wr) mem[wr_ptr] <= push_data;
    end

`ifdef PSUM_MC_ROUTER_DROP_CNT_EN
    logic stall;

    // Count only stalls caused by a full FIFO, not the config-phase gating.
    assign stall = !config_state && full &&
                   (chain ? bus.last_pe_data_valid : (match && bus.bus_data_valid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (cfg_wr) begin
            drop_cnt <= '0;
        end else if (stall && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_psum_mc_router.sv
// tb/tb_psum_mc_router.sv - scoreboard testbench for psum_mc_router

module tb_psum_mc_router;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        config_state;
    logic        ce;
    logic [7:0]  source_id;
    logic [7:0]  dest_id;
    logic        pe_mac_finish;
    logic        pe_ready;
    logic [2:0]  fifo_level;
    logic [15:0] drop_cnt;

    int n_pass  = 0;
    int n_total = 0;
    logic [15:0] exp_q[$];

    psum_mc_router_if #(.DATA_WIDTH(16)) bif ();

    psum_mc_router #(
        .DATA_WIDTH(16),
        .ID_WIDTH  (8),
        .FIFO_DEPTH(4),
        .CNT_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .config_state (config_state),
        .ce           (ce),
        .source_id    (source_id),
        .dest_id      (dest_id),
        .pe_mac_finish(pe_mac_finish),
        .pe_ready     (pe_ready),
        .fifo_level   (fifo_level),
        .drop_cnt     (drop_cnt),
        .bus          (bif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every beat the PE consumes is compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bif.pe_psum_in_en && bif.pe_psum_rdy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {16'h0, bif.pe_psum_in}, 32'hFFFF_FFFF);
            end else begin
                check("psum_data", {16'h0, bif.pe_psum_in}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] id);
        config_state = 1'b1;
        ce           = 1'b1;
        dest_id      = id;
        tick();
        config_state = 1'b0;
        ce           = 1'b0;
    endtask

    task automatic up_push(input logic [15:0] d);
        bif.last_pe_data_in    = d;
        bif.last_pe_data_valid = 1'b1;
        exp_q.push_back(d);
        tick();
        bif.last_pe_data_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; config_state = 1'b0; ce = 1'b0;
        source_id = 8'h00; dest_id = 8'h00; pe_mac_finish = 1'b0;
        bif.bus_data_in = '0; bif.bus_data_valid = 1'b0;
        bif.last_pe_data_in = '0; bif.last_pe_data_valid = 1'b0;
        bif.pe_psum_rdy = 1'b0;

        // Reset state: stored_id = 0 matches source_id = 0 on the bus path.
        repeat (2) @(negedge clk);
        check("rst_level", fifo_level, 0);
        check("rst_en", bif.pe_psum_in_en, 0);
        check("rst_psum", {16'h0, bif.pe_psum_in}, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_bus_rdy", bif.bus_data_ready, 1);
        check("rst_up_rdy", bif.last_pe_data_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Config and match on the bus path.
        cfg(8'h0A);
        source_id = 8'h05;
        bif.bus_data_in = 16'h1234; bif.bus_data_valid = 1'b1;
        exp_q.push_back(16'h1234);
        @(negedge clk);
        check("match_bus_rdy", bif.bus_data_ready, 1);
        tick();
        bif.bus_data_valid = 1'b0;
        @(negedge clk);
        check("match_en", bif.pe_psum_in_en, 1);
        check("match_head", {16'h0, bif.pe_psum_in}, 32'h1234);
        check("match_level", fifo_level, 1);
        pe_mac_finish = 1'b1;
        #1;
        check("match_pe_ready", pe_ready, 1);
        tick();
        bif.pe_psum_rdy = 1'b1;
        tick();
        bif.pe_psum_rdy = 1'b0;
        pe_mac_finish = 1'b0;

        // Mismatch: nothing accepted, no request even with MAC finished.
        source_id = 8'h06;
        bif.bus_data_in = 16'hBEEF; bif.bus_data_valid = 1'b1;
        pe_mac_finish = 1'b1;
        @(negedge clk);
        check("mis_bus_rdy", bif.bus_data_ready, 0);
        check("mis_pe_ready", pe_ready, 0);
        tick();
        bif.bus_data_valid = 1'b0; pe_mac_finish = 1'b0;
        @(negedge clk);
        check("mis_level", fifo_level, 0);

        // Chain: upstream only, bus ignored despite a match.
        cfg(8'h0B);
        source_id = 8'h05;
        bif.bus_data_in = 16'hDEAD; bif.bus_data_valid = 1'b1;
        bif.pe_psum_rdy = 1'b1;
        @(negedge clk);
        check("chain_bus_rdy", bif.bus_data_ready, 0);
        check("chain_up_rdy", bif.last_pe_data_ready, 1);
        tick();
        for (int i = 1; i <= 3; i++) up_push(16'(i));
        repeat (3) tick();
        bif.bus_data_valid = 1'b0;
        @(negedge clk);
        check("chain_level", fifo_level, 0);

        // Fill and backpressure.
        bif.pe_psum_rdy = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            bif.last_pe_data_in    = 16'h0010 + 16'(i);
            bif.last_pe_data_valid = 1'b1;
            if (i < 4) exp_q.push_back(16'h0010 + 16'(i));
            if (i == 4) begin
                @(negedge clk);
                check("fill_rdy_at_full", bif.last_pe_data_ready, 0);
            end
            tick();
        end
        bif.last_pe_data_valid = 1'b0;
        @(negedge clk);
        check("fill_level", fifo_level, 4);
        check("fill_up_rdy", bif.last_pe_data_ready, 0);
`ifdef PSUM_MC_ROUTER_DROP_CNT_EN
        check("fill_drop", drop_cnt, 2);
`else
        check("fill_drop", drop_cnt, 0);
`endif
        tick();
        bif.pe_psum_rdy = 1'b1;
        bif.last_pe_data_in = 16'h0020; bif.last_pe_data_valid = 1'b1;
        @(negedge clk);
        check("full_pop_rdy", bif.last_pe_data_ready, 0);
        tick();
        exp_q.push_back(16'h0020);
        @(negedge clk);
        check("after_pop_rdy", bif.last_pe_data_ready, 1);
        tick();
        bif.last_pe_data_valid = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        check("drain_level", fifo_level, 0);

        // Simultaneous push and pop at level 2.
        bif.pe_psum_rdy = 1'b0;
        tick();
        up_push(16'h0030);
        up_push(16'h0031);
        @(negedge clk);
        check("pp_level_pre", fifo_level, 2);
        tick();
        bif.pe_psum_rdy = 1'b1;
        bif.last_pe_data_in = 16'h0032; bif.last_pe_data_valid = 1'b1;
        exp_q.push_back(16'h0032);
        tick();
        bif.last_pe_data_valid = 1'b0;
        bif.pe_psum_rdy = 1'b0;
        @(negedge clk);
        check("pp_level_post", fifo_level, 2);
        tick();
        bif.pe_psum_rdy = 1'b1;
        repeat (4) tick();
        bif.pe_psum_rdy = 1'b0;

        // Asynchronous reset flush at level 3.
        up_push(16'h0040); up_push(16'h0041); up_push(16'h0042);
        @(negedge clk);
        check("flush_level_pre", fifo_level, 3);
        #2;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("arst_level", fifo_level, 0);
        check("arst_en", bif.pe_psum_in_en, 0);
        check("arst_psum", {16'h0, bif.pe_psum_in}, 0);
        check("arst_drop", drop_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Config-write flush at level 3.
        cfg(8'h0B);
        up_push(16'h0050); up_push(16'h0051); up_push(16'h0052);
        @(negedge clk);
        check("cflush_level_pre", fifo_level, 3);
        tick();
        exp_q.delete();
        cfg(8'h0B);
        @(negedge clk);
        check("cflush_level", fifo_level, 0);
        check("cflush_en", bif.pe_psum_in_en, 0);
        tick();

        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
